daisy_tx_sched: RTL and testbench
=================================

DAISY_TX_SCHED -- requirements
Module: daisy_tx_sched

Interface
REQ-001 Parameter TRAIN_MIN, default 16, meaning minimum training words transmitted per training episode (range 1..255).
REQ-002 par_clk_i  in  1  parallel clock; all logic on its rising edge.
REQ-003 par_rst_i  in  1  synchronous, active-high reset.
REQ-004 cfg_en_i  in  1  link enable; 0 forces DIS state.
REQ-005 cfg_train_i  in  1  training request.
REQ-006 cfg_train_pat_i  in  16  training word.
REQ-007 cmd_dv_i, cmd_dat_i  in  1, 16  command source valid, data.
REQ-008 cmd_rdy_o  out  1  command word accepted when cmd_dv_i & cmd_rdy_o.
REQ-009 usr_dv_i, usr_dat_i  in  1, 16  user source valid, data.
REQ-010 usr_rdy_o  out  1  user word accepted when usr_dv_i & usr_rdy_o.
REQ-011 tx_rdy_i  in  1  serializer ready; one-cycle pulse every 4th cycle.
REQ-012 tx_dv_o, tx_dat_o  out  1, 16  word offered to serializer; consumed when tx_dv_o & tx_rdy_i.
REQ-013 link_up_o  out  1  high while in RUN.
REQ-014 tx_cnt_o  out  32  count of consumed source (non-training) words.

Function
REQ-015 Single output holding register (out_v, out_d, out_src) shall drive tx_dv_o = out_v, tx_dat_o = out_d; out_src marks training or source origin.
REQ-016 slot_free = ~out_v | tx_rdy_i; a new word shall load only when slot_free; a consumed word not replaced shall clear out_v.
REQ-017 States: DIS, TRAIN, RUN.
REQ-018 Any state: cfg_en_i=0 -> DIS at the next edge; the same edge clears out_v (pending word discarded, not counted).
REQ-019 DIS -> TRAIN when cfg_en_i=1; train counter cleared on entry.
REQ-020 TRAIN: load cfg_train_pat_i (sampled at load) whenever slot_free; increment train counter (saturating at 255) on each consumed training word.
REQ-021 TRAIN -> RUN when train counter >= TRAIN_MIN and cfg_train_i=0; cfg_train_i=1 keeps TRAIN indefinitely.
REQ-022 RUN -> TRAIN when cfg_train_i=1; a word already in the holding register shall still be transmitted and counted.
REQ-023 cmd_rdy_o/usr_rdy_o shall be 0 outside RUN, and 0 in RUN whenever cfg_train_i=1 or cfg_en_i=0.
REQ-024 RUN grant, combinational: both pending -> round-robin on last-granted source (cmd first after reset); one pending -> that source; rdy_o = grant & slot_free.
REQ-025 Accepted word shall appear on tx_dv_o/tx_dat_o the cycle after acceptance (1-cycle latency); last-granted pointer updates only on acceptance.
REQ-026 At most one source accepted per cycle; never both rdy_o high together.
REQ-027 No source pending in RUN: no load; tx_dv_o drops after consumption (serializer transmits zeros).
REQ-028 tx_cnt_o shall increment by 1 on each consumed word with source origin, wrapping 0xFFFFFFFF -> 0.
REQ-029 Valid held without ready shall not be lost; data need not be stable before acceptance.

Reset
REQ-030 On par_rst_i=1: state DIS, out_v=0, out_d=0, tx_cnt_o=0, train counter=0, last-grant=usr (cmd wins next tie), all rdy_o=0, link_up_o=0.
REQ-031 Reset overrides all other inputs in the same cycle.

Verification
REQ-032 Reset, cfg_en_i=1, cfg_train_i=0, pat=0xA5F0, TRAIN_MIN=16 -> exactly 16 consumed 0xA5F0 words, then link_up_o=1.
REQ-033 RUN, cmd and usr held valid with data 0x1111/0x2222 -> consumed order 0x1111,0x2222,0x1111,...; tx_cnt_o=+1 per consumption.
REQ-034 RUN, word 0x3333 in register, cfg_train_i raised -> 0x3333 transmitted and counted, then pattern words; rdy_o low throughout TRAIN.
REQ-035 cfg_en_i dropped with word pending -> word never consumed, tx_cnt_o unchanged, state DIS next cycle, re-enable re-trains 16 words.
REQ-036 tx_cnt_o preloaded near 0xFFFFFFFF by 2 consumed words -> reads 0x00000001.
REQ-037 Only usr_dv_i pulsed once, 0xBEEF -> tx_dv_o high next cycle, low after tx_rdy_i consumption.

Source files
------------

// File: rtl/daisy_tx_sched.sv
// Daisy-link transmit scheduler: trains the link, then arbitrates
// command/user words into a single serializer holding register.
//
// Ports:
//   par_clk_i, par_rst_i        clock, synchronous active-high reset
//   cfg_en_i                    link enable (0 forces DIS)
//   cfg_train_i                 training request
//   cfg_train_pat_i[15:0]       training word
//   cmd_dv_i/cmd_dat_i/cmd_rdy_o  command source handshake
//   usr_dv_i/usr_dat_i/usr_rdy_o  user source handshake
//   tx_rdy_i                    serializer ready (1 pulse per 4 cycles)
//   tx_dv_o/tx_dat_o            word offered to serializer
//   link_up_o                   high while in RUN
//   tx_cnt_o[31:0]              consumed source-word count
module daisy_tx_sched #(
  parameter int unsigned TRAIN_MIN = 16
) (
  input  logic        par_clk_i,
  input  logic        par_rst_i,
  input  logic        cfg_en_i,
  input  logic        cfg_train_i,
  input  logic [15:0] cfg_train_pat_i,
  input  logic        cmd_dv_i,
  input  logic [15:0] cmd_dat_i,
  output logic        cmd_rdy_o,
  input  logic        usr_dv_i,
  input  logic [15:0] usr_dat_i,
  output logic        usr_rdy_o,
  input  logic        tx_rdy_i,
  output logic        tx_dv_o,
  output logic [15:0] tx_dat_o,
  output logic        link_up_o,
  output logic [31:0] tx_cnt_o
);

  typedef enum logic [1:0] {
    ST_DIS   = 2'd0,
    ST_TRAIN = 2'd1,
    ST_RUN   = 2'd2
  } state_e;

  localparam logic [7:0] TRAIN_MIN_C = 8'(TRAIN_MIN);

  state_e      state_q, state_d;
  logic        out_v_q, out_v_d;
  logic [15:0] out_d_q, out_d_d;
  logic        out_src_q, out_src_d;
  logic [7:0]  trn_cnt_q, trn_cnt_d;
  logic        last_usr_q, last_usr_d;
  logic [31:0] tx_cnt_q, tx_cnt_d;

  logic slot_free;
  logic consumed;
  logic trn_done;
  logic run_open;
  logic gnt_cmd;
  logic gnt_usr;
  logic cmd_acc;
  logic usr_acc;

  // Holding register can take a new word when empty or
  // when its current word leaves this cycle.
  assign slot_free = ~out_v_q | tx_rdy_i;
  assign consumed  = out_v_q & tx_rdy_i;
  assign trn_done  = trn_cnt_q >= TRAIN_MIN_C;

  // Sources are only ever opened in a clean RUN cycle.
  assign run_open = (state_q == ST_RUN)
                  & cfg_en_i
                  & ~cfg_train_i
                  & ~par_rst_i;

  // Round-robin on tie: the source not granted last wins.
  always_comb begin
    gnt_cmd = 1'b0;
    gnt_usr = 1'b0;
    if (cmd_dv_i & usr_dv_i) begin
      gnt_cmd = last_usr_q;
      gnt_usr = ~last_usr_q;
    end else begin
      gnt_cmd = cmd_dv_i;
      gnt_usr = usr_dv_i;
    end
  end

  assign cmd_acc = run_open & slot_free & gnt_cmd;
  assign usr_acc = run_open & slot_free & gnt_usr;

  assign cmd_rdy_o = cmd_acc;
  assign usr_rdy_o = usr_acc;
  assign tx_dv_o   = out_v_q;
  assign tx_dat_o  = out_d_q;
  assign link_up_o = (state_q == ST_RUN);
  assign tx_cnt_o  = tx_cnt_q;

  always_comb begin
    state_d    = state_q;
    out_v_d    = out_v_q & ~consumed;
    out_d_d    = out_d_q;
    out_src_d  = out_src_q;
    last_usr_d = last_usr_q;
    trn_cnt_d  = trn_cnt_q;
    tx_cnt_d   = tx_cnt_q;

    if (consumed & out_src_q) begin
      tx_cnt_d = tx_cnt_q + 32'd1;
    end
    if (consumed & ~out_src_q & (trn_cnt_q != 8'hFF)) begin
      trn_cnt_d = trn_cnt_q + 8'd1;
    end

    unique case (state_q)
      ST_DIS: begin
        state_d   = ST_TRAIN;
        trn_cnt_d = 8'd0;
      end
      ST_TRAIN: begin
        if (slot_free) begin
          out_v_d   = 1'b1;
          out_d_d   = cfg_train_pat_i;
          out_src_d = 1'b0;
        end
        if (trn_done & ~cfg_train_i) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (cfg_train_i) begin
          state_d = ST_TRAIN;
        end else begin
          unique case (1'b1)
            cmd_acc: begin
              out_v_d    = 1'b1;
              out_d_d    = cmd_dat_i;
              out_src_d  = 1'b1;
              last_usr_d = 1'b0;
            end
            usr_acc: begin
              out_v_d    = 1'b1;
              out_d_d    = usr_dat_i;
              out_src_d  = 1'b1;
              last_usr_d = 1'b1;
            end
            default: begin
            end
          endcase
        end
      end
      default: begin
        state_d = ST_DIS;
      end
    endcase

    // Disable wins over everything: the pending word is
    // dropped and neither counter sees it.
    if (!cfg_en_i) begin
      state_d   = ST_DIS;
      out_v_d   = 1'b0;
      tx_cnt_d  = tx_cnt_q;
      trn_cnt_d = trn_cnt_q;
    end
  end

  always_ff @(posedge par_clk_i) begin
    if (par_rst_i) begin
      state_q    <= ST_DIS;
      out_v_q    <= 1'b0;
      out_d_q    <= 16'd0;
      out_src_q  <= 1'b0;
      trn_cnt_q  <= 8'd0;
      last_usr_q <= 1'b1;
      tx_cnt_q   <= 32'd0;
    end else begin
      state_q    <= state_d;
      out_v_q    <= out_v_d;
      out_d_q    <= out_d_d;
      out_src_q  <= out_src_d;
      trn_cnt_q  <= trn_cnt_d;
      last_usr_q <= last_usr_d;
      tx_cnt_q   <= tx_cnt_d;
    end
  end

endmodule

// File: tb/tb_daisy_tx_sched.sv
// Self-checking bench for daisy_tx_sched: directed scenarios plus
// randomized traffic against a behavioural link model.
module tb_daisy_tx_sched;

  localparam int TMIN = 16;

  logic        clk = 1'b0;
  logic        par_rst_i = 1'b1;
  logic        cfg_en_i = 1'b0;
  logic        cfg_train_i = 1'b0;
  logic [15:0] cfg_train_pat_i = 16'hA5F0;
  logic        cmd_dv_i = 1'b0;
  logic [15:0] cmd_dat_i = 16'h0;
  logic        cmd_rdy_o;
  logic        usr_dv_i = 1'b0;
  logic [15:0] usr_dat_i = 16'h0;
  logic        usr_rdy_o;
  logic        tx_rdy_i = 1'b0;
  logic        tx_dv_o;
  logic [15:0] tx_dat_o;
  logic        link_up_o;
  logic [31:0] tx_cnt_o;

  always #5 clk = ~clk;

  daisy_tx_sched #(.TRAIN_MIN(TMIN)) dut (
    .par_clk_i       (clk),
    .par_rst_i       (par_rst_i),
    .cfg_en_i        (cfg_en_i),
    .cfg_train_i     (cfg_train_i),
    .cfg_train_pat_i (cfg_train_pat_i),
    .cmd_dv_i        (cmd_dv_i),
    .cmd_dat_i       (cmd_dat_i),
    .cmd_rdy_o       (cmd_rdy_o),
    .usr_dv_i        (usr_dv_i),
    .usr_dat_i       (usr_dat_i),
    .usr_rdy_o       (usr_rdy_o),
    .tx_rdy_i        (tx_rdy_i),
    .tx_dv_o         (tx_dv_o),
    .tx_dat_o        (tx_dat_o),
    .link_up_o       (link_up_o),
    .tx_cnt_o        (tx_cnt_o)
  );

  int tests = 0;
  int fails = 0;
  int phase = 0;

  // Link model: mode 0=disabled, 1=training, 2=running.
  int          m_mode = 0;
  bit          m_v = 0;
  logic [15:0] m_d = 16'h0;
  bit          m_src = 0;
  int          m_trn = 0;
  bit          m_last_usr = 1;
  logic [31:0] m_cnt = 32'h0;

  logic [15:0] acc_q[$];
  logic [15:0] cons_log[$];
  bit          obs_acc;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: inputs already set at the falling edge.
  task automatic tick();
    bit e_slot, e_open, e_cmd, e_usr, live, cons;
    int old_trn;
    logic [15:0] exp_w;
    tx_rdy_i = (phase == 3);
    phase = (phase + 1) % 4;
    #1;
    e_slot = !m_v || tx_rdy_i;
    e_open = (m_mode == 2) && cfg_en_i && !cfg_train_i && !par_rst_i;
    e_cmd = 0;
    e_usr = 0;
    if (e_open && e_slot) begin
      if (cmd_dv_i && usr_dv_i) begin
        if (m_last_usr) e_cmd = 1;
        else e_usr = 1;
      end else if (cmd_dv_i) e_cmd = 1;
      else if (usr_dv_i) e_usr = 1;
    end
    chk("tx_dv", tx_dv_o, m_v);
    if (m_v) chk("tx_dat", tx_dat_o, m_d);
    chk("cmd_rdy", cmd_rdy_o, e_cmd);
    chk("usr_rdy", usr_rdy_o, e_usr);
    chk("both_rdy", cmd_rdy_o & usr_rdy_o, 0);
    chk("link_up", link_up_o, m_mode == 2);
    chk("tx_cnt", tx_cnt_o, m_cnt);

    obs_acc = (cmd_rdy_o && cmd_dv_i) || (usr_rdy_o && usr_dv_i);
    live = !par_rst_i && cfg_en_i;
    cons = live && m_v && tx_rdy_i;
    if (live && tx_dv_o && tx_rdy_i) cons_log.push_back(tx_dat_o);
    if (cons && m_src) begin
      if (acc_q.size() > 0) begin
        exp_w = acc_q.pop_front();
        chk("sb_order", tx_dat_o, exp_w);
      end else begin
        chk("sb_underflow", 32'(acc_q.size()), 32'd1);
      end
    end else if (!live && m_v && m_src && acc_q.size() > 0) begin
      void'(acc_q.pop_front());
    end
    if (e_cmd) acc_q.push_back(cmd_dat_i);
    if (e_usr) acc_q.push_back(usr_dat_i);

    if (par_rst_i) begin
      m_mode = 0; m_v = 0; m_d = 16'h0; m_src = 0;
      m_trn = 0; m_last_usr = 1; m_cnt = 32'h0;
    end else if (!cfg_en_i) begin
      m_mode = 0;
      m_v = 0;
    end else begin
      old_trn = m_trn;
      if (cons && m_src) m_cnt = m_cnt + 32'd1;
      if (cons && !m_src && m_trn < 255) m_trn++;
      if (cons) m_v = 0;
      case (m_mode)
        0: begin m_mode = 1; m_trn = 0; end
        1: begin
          if (e_slot) begin
            m_v = 1; m_d = cfg_train_pat_i; m_src = 0;
          end
          if (old_trn >= TMIN && !cfg_train_i) m_mode = 2;
        end
        default: begin
          if (cfg_train_i) m_mode = 1;
          else if (e_cmd) begin
            m_v = 1; m_d = cmd_dat_i; m_src = 1; m_last_usr = 0;
          end else if (e_usr) begin
            m_v = 1; m_d = usr_dat_i; m_src = 1; m_last_usr = 1;
          end
        end
      endcase
    end
    @(negedge clk);
  endtask

  task automatic wait_link(output int n);
    bit up;
    up = 0;
    n = 0;
    cons_log.delete();
    for (int i = 0; i < 300 && !up; i++) begin
      tick();
      up = link_up_o;
    end
    foreach (cons_log[k]) if (cons_log[k] == cfg_train_pat_i) n++;
    chk("link_timeout", up, 1);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && tx_dv_o; i++) tick();
    chk("drain", tx_dv_o, 0);
  endtask

  task automatic wait_acc();
    bit got;
    got = 0;
    for (int i = 0; i < 12 && !got; i++) begin
      tick();
      got = obs_acc;
    end
    chk("acc_timeout", got, 1);
  endtask

  task automatic collect_src(input int want);
    int i;
    i = 0;
    while (i < 80) begin
      tick();
      i++;
      if (cons_log.size() > 0 && cons_log[cons_log.size()-1] == cfg_train_pat_i)
        void'(cons_log.pop_back());
      if (cons_log.size() >= want) break;
    end
    chk("collect_timeout", cons_log.size() >= want, 1);
  endtask

  initial begin
    int n;
    logic [31:0] base;
    logic [15:0] exp_rr[4];
    @(negedge clk);
    for (int i = 0; i < 3; i++) tick();
    chk("rst_cnt", tx_cnt_o, 32'h0);
    chk("rst_link", link_up_o, 1'b0);
    chk("rst_dv", tx_dv_o, 1'b0);
    chk("rst_rdy", {cmd_rdy_o, usr_rdy_o}, 2'b00);

    // Training to link-up
    par_rst_i = 0;
    cfg_en_i = 1;
    cfg_train_pat_i = 16'hA5F0;
    wait_link(n);
    chk("train_words", n, TMIN);

    // Round-robin with both sources held valid
    cmd_dat_i = 16'h1111;
    usr_dat_i = 16'h2222;
    cmd_dv_i = 1;
    usr_dv_i = 1;
    base = m_cnt;
    cons_log.delete();
    collect_src(4);
    exp_rr = '{16'h1111, 16'h2222, 16'h1111, 16'h2222};
    for (int k = 0; k < 4 && k < cons_log.size(); k++)
      chk("rr_order", cons_log[k], exp_rr[k]);
    chk("rr_cnt", tx_cnt_o, base + 32'd4);
    cmd_dv_i = 0;
    usr_dv_i = 0;
    drain();

    // Retrain with a word already held
    cmd_dat_i = 16'h3333;
    cmd_dv_i = 1;
    base = m_cnt;
    wait_acc();
    cfg_train_i = 1;
    usr_dat_i = 16'h5555;
    usr_dv_i = 1;
    cons_log.delete();
    for (int i = 0; i < 24; i++) begin
      tick();
      chk("train_rdy", {cmd_rdy_o, usr_rdy_o}, 2'b00);
    end
    chk("rt_len", cons_log.size() >= 3, 1);
    if (cons_log.size() >= 3) begin
      chk("rt_first", cons_log[0], 16'h3333);
      chk("rt_pat1", cons_log[1], 16'hA5F0);
      chk("rt_pat2", cons_log[2], 16'hA5F0);
    end
    chk("rt_cnt", tx_cnt_o, base + 32'd1);
    chk("rt_link", link_up_o, 1'b0);
    cmd_dv_i = 0;
    usr_dv_i = 0;
    cfg_train_i = 0;
    for (int i = 0; i < 12; i++) tick();
    chk("rt_back", link_up_o, 1'b1);
    drain();

    // Disable with a word pending
    usr_dat_i = 16'h4444;
    usr_dv_i = 1;
    wait_acc();
    usr_dv_i = 0;
    base = m_cnt;
    cfg_en_i = 0;
    cons_log.delete();
    tick();
    chk("dis_link", link_up_o, 1'b0);
    chk("dis_dv", tx_dv_o, 1'b0);
    chk("dis_cnt", tx_cnt_o, base);
    cfg_en_i = 1;
    wait_link(n);
    chk("retrain_words", n, TMIN);
    chk("dis_cnt2", tx_cnt_o, base);
    foreach (cons_log[k]) chk("dis_lost", cons_log[k] == 16'h4444, 0);
    drain();

    // Counter wrap
    force dut.tx_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.tx_cnt_q;
    m_cnt = 32'hFFFF_FFFF;
    cmd_dat_i = 16'h6666;
    cmd_dv_i = 1;
    cons_log.delete();
    collect_src(2);
    cmd_dv_i = 0;
    chk("wrap_cnt", tx_cnt_o, 32'h0000_0001);
    drain();

    // Single user pulse
    usr_dat_i = 16'hBEEF;
    usr_dv_i = 1;
    tick();
    usr_dv_i = 0;
    chk("pulse_dv", tx_dv_o, 1'b1);
    chk("pulse_dat", tx_dat_o, 16'hBEEF);
    cons_log.delete();
    for (int i = 0; i < 6 && cons_log.size() == 0; i++) tick();
    chk("pulse_cons", cons_log.size(), 1);
    chk("pulse_drop", tx_dv_o, 1'b0);

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      par_rst_i = ($urandom_range(0, 299) == 0);
      cfg_en_i = ($urandom_range(0, 79) != 0);
      if ($urandom_range(0, 39) == 0) cfg_train_i = ~cfg_train_i;
      if ($urandom_range(0, 49) == 0) cfg_train_pat_i = 16'($urandom);
      cmd_dv_i = ($urandom_range(0, 2) != 0);
      usr_dv_i = ($urandom_range(0, 2) != 0);
      cmd_dat_i = 16'($urandom);
      usr_dat_i = 16'($urandom);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
